button_enable_gen: RTL and testbench

BUTTON_ENABLE_GEN -- requirements
Module: button_enable_gen

---
 rtl/button_enable_gen.sv | 149 ++++++++++++++
 tb/tb_button_enable_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_enable_gen.sv
// button_enable_gen
//   Turns a raw, bouncy pushbutton into a clean debounced level and a
//   single-cycle count-enable pulse stream: one pulse on press and, when
//   REPEAT_EN is set, auto-repeat pulses while the button stays held.
//
// Parameters
//   DEBOUNCE_CYCLES : synchronized cycles a new level must persist (1..2^20)
//   REPEAT_EN       : 1 = auto-repeat while held, 0 = one pulse per press
//   REPEAT_DELAY    : cycles from press pulse to first repeat pulse (2..2^24)
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses (2..2^24)
//
// Ports
//   clock_i   : single clock, all state on the rising edge
//   reset_i   : synchronous active-high reset
//   button_i  : raw asynchronous button level, 1 = pressed
//   enable_o  : registered single-cycle count-enable pulse
//   pressed_o : registered debounced button level
module button_enable_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 50000,
  parameter int unsigned REPEAT_PERIOD   = 10000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_i,
  output logic enable_o,
  output logic pressed_o
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    HELD_REPEAT
  } state_t;

  // Two-flop synchronizer; only btn_s is used downstream.
  logic sync_q;
  logic btn_s;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= button_i;
      btn_s  <= sync_q;
    end
  end

  // Debounce: any cycle where btn_s agrees with the accepted level clears
  // the counter, so a bounce shorter than DEBOUNCE_CYCLES never gets through.
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_accept;
  logic             press_evt;
  logic             release_evt;

  assign deb_accept  = (btn_s != pressed_o) && (deb_cnt == DEB_LAST);
  assign press_evt   = deb_accept &&  btn_s;
  assign release_evt = deb_accept && !btn_s;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      deb_cnt   <= '0;
      pressed_o <= 1'b0;
    end else if (btn_s == pressed_o) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      pressed_o <= btn_s;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Pulse FSM. It reacts to the debounce accept event rather than to the
  // registered pressed_o, so the press pulse lands on the same edge that
  // pressed_o rises and a release on the expiry edge suppresses the pulse.
  state_t           state;
  state_t           state_n;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_n;
  logic             enable_n;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= RELEASED;
      timer    <= '0;
      enable_o <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      enable_o <= enable_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    enable_n = 1'b0;
    case (state)
      RELEASED: begin
        timer_n = '0;
        if (press_evt) begin
          state_n  = HELD_DELAY;
          enable_n = 1'b1;
        end
      end
      HELD_DELAY: begin
        if (release_evt) begin
          state_n = RELEASED;
          timer_n = '0;
        end else if (REPEAT_EN != 0) begin
          if (timer == DELAY_LAST) begin
            state_n  = HELD_REPEAT;
            timer_n  = '0;
            enable_n = 1'b1;
          end else begin
            timer_n = timer + TMR_W'(1);
          end
        end
      end
      HELD_REPEAT: begin
        if (release_evt) begin
          state_n = RELEASED;
          timer_n = '0;
        end else if (timer == PERIOD_LAST) begin
          timer_n  = '0;
          enable_n = 1'b1;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_enable_gen.sv
// Scoreboard bench for button_enable_gen (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). Stimulus pushes hand-computed pulse / level-change edge
// numbers into queues; a negedge monitor pops and compares whenever the DUT
// shows a pulse or a pressed_o change. A button first sampled high at edge E
// is accepted at edge E+5; a release first sampled at edge F falls at F+5.
module tb_button_enable_gen;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic button_i = 1'b0;
  logic enable_o, pressed_o;
  logic enable_nr, pressed_nr;

  always #5 clock_i = ~clock_i;

  button_enable_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .button_i(button_i),
    .enable_o(enable_o),
    .pressed_o(pressed_o)
  );

  button_enable_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(0),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut_nr (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .button_i(button_i),
    .enable_o(enable_nr),
    .pressed_o(pressed_nr)
  );

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;

  int exp_pulse[$];
  int exp_nr[$];
  int exp_pr_cyc[$];
  int exp_pr_lvl[$];

  logic       prev_pr = 1'b0;
  logic [3:0] cnt4 = 4'd0;

  // Downstream 4-bit counter fed by enable_o.
  always @(posedge clock_i) if (enable_o === 1'b1) cnt4 <= cnt4 + 4'd1;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endfunction

  task automatic push_p(input int c);
    exp_pulse.push_back(c);
    n_pushed++;
  endtask

  task automatic push_pr(input int c, input int lvl);
    exp_pr_cyc.push_back(c);
    exp_pr_lvl.push_back(lvl);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  // Monitor
  always @(negedge clock_i) begin
    if (enable_o === 1'b1) begin
      if (exp_pulse.size() == 0) check("unexpected_pulse", cyc, -1);
      else check("pulse_edge", cyc, exp_pulse.pop_front());
    end
    if (enable_nr === 1'b1) begin
      if (exp_nr.size() == 0) check("unexpected_pulse_norepeat", cyc, -1);
      else check("pulse_edge_norepeat", cyc, exp_nr.pop_front());
    end
    if (pressed_o !== prev_pr) begin
      if (exp_pr_cyc.size() == 0) check("unexpected_pressed_change", cyc, -1);
      else begin
        check("pressed_edge", cyc, exp_pr_cyc.pop_front());
        check("pressed_level", int'(pressed_o === 1'b1), exp_pr_lvl.pop_front());
      end
      prev_pr = pressed_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, p, r, p2;
    reset_i  = 1'b1;
    button_i = 1'b1;
    idle(3);
    check("reset_enable", int'(enable_o === 1'b1), 0);
    check("reset_pressed", int'(pressed_o === 1'b1), 0);
    check("reset_enable_norepeat", int'(enable_nr === 1'b1), 0);
    check("reset_pressed_norepeat", int'(pressed_nr === 1'b1), 0);
    button_i = 1'b0;
    reset_i  = 1'b0;
    idle(6);

    // Clean press, held 10 samples: one pulse, fall 6 edges after release.
    e = cyc + 1; p = e + 5;
    push_p(p); exp_nr.push_back(p);
    push_pr(p, 1); push_pr(e + 15, 0);
    button_i = 1'b1; idle(10);
    button_i = 1'b0; idle(20);

    // Bounce: 3 high, 1 low, 3 high -> nothing.
    button_i = 1'b1; idle(3);
    button_i = 1'b0; idle(1);
    button_i = 1'b1; idle(3);
    button_i = 1'b0; idle(15);

    // Hold 60: repeats at +20,+28,...,+52; fall at P+60 suppresses that pulse.
    e = cyc + 1; p = e + 5;
    push_p(p); push_p(p + 20); push_p(p + 28); push_p(p + 36);
    push_p(p + 44); push_p(p + 52);
    exp_nr.push_back(p);
    push_pr(p, 1); push_pr(e + 65, 0);
    button_i = 1'b1; idle(60);
    button_i = 1'b0; idle(20);

    // Release landing on P+28: no pulse there.
    e = cyc + 1; p = e + 5;
    push_p(p); push_p(p + 20);
    exp_nr.push_back(p);
    push_pr(p, 1); push_pr(p + 28, 0);
    button_i = 1'b1; idle(28);
    button_i = 1'b0; idle(20);

    // Reset at P+10 while held, then a fresh press and schedule.
    e = cyc + 1; p = e + 5; r = p + 10; p2 = r + 6;
    push_p(p); exp_nr.push_back(p);
    push_p(p2); push_p(p2 + 20); push_p(p2 + 28);
    exp_nr.push_back(p2);
    push_pr(p, 1); push_pr(r, 0); push_pr(p2, 1); push_pr(p2 + 35, 0);
    button_i = 1'b1; idle(15);
    reset_i = 1'b1; idle(1);
    check("midpress_reset_enable", int'(enable_o === 1'b1), 0);
    check("midpress_reset_pressed", int'(pressed_o === 1'b1), 0);
    reset_i = 1'b0;
    idle(35);
    button_i = 1'b0; idle(20);

    check("leftover_pulses", exp_pulse.size(), 0);
    check("leftover_pulses_norepeat", exp_nr.size(), 0);
    check("leftover_pressed", exp_pr_cyc.size(), 0);
    check("counter_4_16", int'(cnt4), n_pushed % 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
